// File: rtl/vm_input_conditioner.sv
`default_nettype none
// ============================================================================
// vm_input_conditioner: synchronises and debounces coin buttons and product
// switches, then emits encoded single-cycle coin/selection events.
// Revision: 1.0
// ============================================================================
module vm_input_conditioner #(
   parameter int DB_CYCLES = 500000,
   parameter int CNT_W     = 20
) (
   input  logic       clk,
   input  logic       clr,
   input  logic [2:0] btn_i,
   input  logic [3:0] sw_i,
   output logic       coin_valid_o,
   output logic [2:0] coin_amt_o,
   output logic       coin_err_o,
   output logic       sel_valid_o,
   output logic [2:0] sel_code_o,
   output logic       sel_err_o,
   output logic [3:0] sel_hold_o
);

   localparam int               NBITS   = 7;
   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   typedef enum logic [0:0] {C_ARMED = 1'b0, C_WAIT_REL = 1'b1} coin_state_e;
   typedef enum logic [0:0] {S_IDLE  = 1'b0, S_HELD     = 1'b1} sel_state_e;

   logic [NBITS-1:0] sync1_q;
   logic [NBITS-1:0] sync2_q;
   logic [NBITS-1:0] stable;

   always_ff @(posedge clk) begin
      if (clr) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= {sw_i, btn_i};
         sync2_q <= sync1_q;
      end
   end

   // Any sample matching the accepted level restarts the qualification count.
   for (genvar i = 0; i < NBITS; i++) begin : g_db
      logic             stable_q;
      logic [CNT_W-1:0] cnt_q;

      always_ff @(posedge clk) begin
         if (clr) begin
            stable_q <= 1'b0;
            cnt_q    <= '0;
         end else if (sync2_q[i] == stable_q) begin
            cnt_q    <= '0;
         end else if (cnt_q == DB_LAST) begin
            stable_q <= sync2_q[i];
            cnt_q    <= '0;
         end else begin
            cnt_q    <= cnt_q + CNT_ONE;
         end
      end

      assign stable[i] = stable_q;
   end

   logic [2:0] btn_stb;
   logic [3:0] sw_stb;
   logic       btn_onehot;
   logic       sw_onehot;

   assign btn_stb    = stable[2:0];
   assign sw_stb     = stable[6:3];
   assign btn_onehot = (btn_stb != 3'd0) && ((btn_stb & (btn_stb - 3'd1)) == 3'd0);
   assign sw_onehot  = (sw_stb  != 4'd0) && ((sw_stb  & (sw_stb  - 4'd1)) == 4'd0);

   coin_state_e coin_state_q;
   sel_state_e  sel_state_q;
   logic        coin_valid_q, coin_err_q, sel_valid_q, sel_err_q;
   logic [2:0]  coin_amt_q, coin_amt_d;
   logic [2:0]  sel_code_q, sel_code_d;
   logic [3:0]  sel_hold_q;

   always_comb begin
      coin_amt_d = coin_amt_q;
      case (btn_stb)
         3'b001:  coin_amt_d = 3'd1;
         3'b010:  coin_amt_d = 3'd2;
         3'b100:  coin_amt_d = 3'd5;
         default: coin_amt_d = coin_amt_q;
      endcase
   end

   always_comb begin
      sel_code_d = sel_code_q;
      case (sw_stb)
         4'b0001: sel_code_d = 3'd3;
         4'b0010: sel_code_d = 3'd4;
         4'b0100: sel_code_d = 3'd5;
         4'b1000: sel_code_d = 3'd6;
         default: sel_code_d = sel_code_q;
      endcase
   end

   // In the armed state any nonzero stable vector is necessarily a fresh rise,
   // since re-arming only happens once the vector has fully returned to zero.
   always_ff @(posedge clk) begin
      if (clr) begin
         coin_state_q <= C_ARMED;
         coin_valid_q <= 1'b0;
         coin_err_q   <= 1'b0;
         coin_amt_q   <= 3'd0;
      end else begin
         coin_valid_q <= 1'b0;
         coin_err_q   <= 1'b0;
         if (coin_state_q == C_ARMED) begin
            if (btn_stb != 3'd0) begin
               coin_state_q <= C_WAIT_REL;
               if (btn_onehot) begin
                  coin_valid_q <= 1'b1;
                  coin_amt_q   <= coin_amt_d;
               end else begin
                  coin_err_q   <= 1'b1;
               end
            end
         end else if (btn_stb == 3'd0) begin
            coin_state_q <= C_ARMED;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         sel_state_q <= S_IDLE;
         sel_valid_q <= 1'b0;
         sel_err_q   <= 1'b0;
         sel_code_q  <= 3'd0;
         sel_hold_q  <= 4'd0;
      end else begin
         sel_valid_q <= 1'b0;
         sel_err_q   <= 1'b0;
         sel_hold_q  <= sw_onehot ? sw_stb : 4'd0;
         if (sel_state_q == S_IDLE) begin
            if (sw_stb != 4'd0) begin
               sel_state_q <= S_HELD;
               if (sw_onehot) begin
                  sel_valid_q <= 1'b1;
                  sel_code_q  <= sel_code_d;
               end else begin
                  sel_err_q   <= 1'b1;
               end
            end
         end else if (sw_stb == 4'd0) begin
            sel_state_q <= S_IDLE;
         end
      end
   end

   assign coin_valid_o = coin_valid_q;
   assign coin_amt_o   = coin_amt_q;
   assign coin_err_o   = coin_err_q;
   assign sel_valid_o  = sel_valid_q;
   assign sel_code_o   = sel_code_q;
   assign sel_err_o    = sel_err_q;
   assign sel_hold_o   = sel_hold_q;

endmodule
`default_nettype wire

// File: tb/tb_vm_input_conditioner.sv
`default_nettype none
// ============================================================================
// tb_vm_input_conditioner: directed scenarios with a window-based reference
// model compared every cycle, plus hand-computed latency/value checks.
// Revision: 1.0
// ============================================================================
module tb_vm_input_conditioner;

   localparam int DB = 4;

   logic       clk = 1'b0;
   logic       clr = 1'b1;
   logic [2:0] btn = 3'd0;
   logic [3:0] sw  = 4'd0;
   logic       coin_valid, coin_err, sel_valid, sel_err;
   logic [2:0] coin_amt, sel_code;
   logic [3:0] sel_hold;

   int checks = 0;
   int errors = 0;

   vm_input_conditioner #(.DB_CYCLES(DB), .CNT_W(3)) dut (
      .clk          (clk),
      .clr          (clr),
      .btn_i        (btn),
      .sw_i         (sw),
      .coin_valid_o (coin_valid),
      .coin_amt_o   (coin_amt),
      .coin_err_o   (coin_err),
      .sel_valid_o  (sel_valid),
      .sel_code_o   (sel_code),
      .sel_err_o    (sel_err),
      .sel_hold_o   (sel_hold)
   );

   always #5 clk = ~clk;

   // Reference model: a bit is accepted once the synchronised input has
   // disagreed with the accepted level for DB consecutive edges.
   logic [6:0] hist[$];
   logic [6:0] m_stable = '0;
   bit         coin_armed = 1'b1, sel_armed = 1'b1, m_ok = 1'b0;
   logic       e_cv = 0, e_ce = 0, e_sv = 0, e_se = 0;
   logic [2:0] e_ca = 0, e_sc = 0;
   logic [3:0] e_sh = 0;
   int         cyc = 0;

   function automatic logic [2:0] coin_value(input logic [2:0] b);
      case (b)
         3'b001:  return 3'd1;
         3'b010:  return 3'd2;
         default: return 3'd5;
      endcase
   endfunction

   function automatic logic [2:0] price(input logic [3:0] s);
      case (s)
         4'b0001: return 3'd3;
         4'b0010: return 3'd4;
         4'b0100: return 3'd5;
         default: return 3'd6;
      endcase
   endfunction

   initial begin
      logic [2:0] b;
      logic [3:0] s;
      logic [6:0] nxt;
      bit         all_diff;
      forever begin
         @(posedge clk);
         cyc++;
         if (clr) begin
            hist.delete();
            for (int i = 0; i < DB + 2; i++) hist.push_back(7'd0);
            m_stable = '0; coin_armed = 1; sel_armed = 1; m_ok = 1;
            e_cv = 0; e_ce = 0; e_sv = 0; e_se = 0; e_ca = 0; e_sc = 0; e_sh = 0;
         end else if (m_ok) begin
            b = m_stable[2:0];
            s = m_stable[6:3];
            e_cv = 0; e_ce = 0; e_sv = 0; e_se = 0;
            if (coin_armed && b != 0) begin
               coin_armed = 0;
               if ($countones(b) == 1) begin e_cv = 1; e_ca = coin_value(b); end
               else e_ce = 1;
            end else if (!coin_armed && b == 0) coin_armed = 1;
            if (sel_armed && s != 0) begin
               sel_armed = 0;
               if ($countones(s) == 1) begin e_sv = 1; e_sc = price(s); end
               else e_se = 1;
            end else if (!sel_armed && s == 0) sel_armed = 1;
            e_sh = ($countones(s) == 1) ? s : 4'd0;
            hist.push_back({sw, btn});
            nxt = m_stable;
            for (int bit_i = 0; bit_i < 7; bit_i++) begin
               all_diff = 1;
               for (int k = 0; k < DB; k++)
                  if (hist[hist.size() - 3 - k][bit_i] == m_stable[bit_i]) all_diff = 0;
               if (all_diff) nxt[bit_i] = ~m_stable[bit_i];
            end
            m_stable = nxt;
            void'(hist.pop_front());
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (m_ok) begin
            checks++;
            if ({coin_valid, coin_amt, coin_err, sel_valid, sel_code, sel_err, sel_hold} !==
                {e_cv, e_ca, e_ce, e_sv, e_sc, e_se, e_sh}) begin
               errors++;
               $display("FAIL model-compare cycle %0d: got cv=%b ca=%0d ce=%b sv=%b sc=%0d se=%b sh=%b expected cv=%b ca=%0d ce=%b sv=%b sc=%0d se=%b sh=%b",
                        cyc, coin_valid, coin_amt, coin_err, sel_valid, sel_code, sel_err, sel_hold,
                        e_cv, e_ca, e_ce, e_sv, e_sc, e_se, e_sh);
            end
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic bit pulse_sig(input int w);
      case (w)
         0:       return coin_valid;
         1:       return coin_err;
         default: return sel_valid;
      endcase
   endfunction

   // Edge 0 is the first rising edge after the call; returns -1 on timeout.
   task automatic wait_pulse(input int which, input string name, input int exp_dly);
      int dly = -1;
      for (int n = 0; n < 20; n++) begin
         @(posedge clk);
         @(negedge clk);
         if (pulse_sig(which)) begin
            dly = n;
            break;
         end
      end
      chk(name, dly, exp_dly);
   endtask

   task automatic idle(input int n, output int pulses);
      pulses = 0;
      repeat (n) begin
         @(posedge clk);
         @(negedge clk);
         pulses += int'(coin_valid) + int'(coin_err) + int'(sel_valid) + int'(sel_err);
      end
   endtask

   initial begin
      int p, tot;
      repeat (2) @(negedge clk);
      clr = 1'b0;
      chk("reset outputs", int'({coin_valid, coin_amt, coin_err, sel_valid, sel_code, sel_err, sel_hold}), 0);

      // Clean coin presses
      btn = 3'b010;
      wait_pulse(0, "clean 10c latency", DB + 2);
      chk("clean 10c amt", coin_amt, 2);
      chk("clean 10c err", coin_err, 0);
      idle(1, p);
      chk("pulse width", p, 0);
      btn = 3'b000; idle(10, p);
      btn = 3'b100;
      wait_pulse(0, "clean 25c latency", DB + 2);
      chk("clean 25c amt", coin_amt, 5);
      btn = 3'b000; idle(10, p);

      // Bouncing 5c button
      tot = 0;
      for (int r = 0; r < 5; r++) begin
         btn = 3'b001; idle(3, p); tot += p;
         btn = 3'b000; idle(1, p); tot += p;
      end
      chk("bounce no pulse", tot, 0);
      btn = 3'b001;
      wait_pulse(0, "bounce latency", DB + 2);
      chk("bounce amt", coin_amt, 1);
      btn = 3'b000; idle(10, p);

      // Multi-press
      btn = 3'b101;
      wait_pulse(1, "multi err latency", DB + 2);
      chk("multi no valid", coin_valid, 0);
      chk("multi amt held", coin_amt, 1);
      btn = 3'b000; idle(10, p);
      btn = 3'b010;
      wait_pulse(0, "held 10c latency", DB + 2);
      btn = 3'b011; idle(12, p);
      chk("press while held", p, 0);
      btn = 3'b000; idle(10, p);
      btn = 3'b001;
      wait_pulse(0, "rearm 5c latency", DB + 2);
      chk("rearm 5c amt", coin_amt, 1);
      btn = 3'b000; idle(10, p);

      // Selection
      sw = 4'b0100;
      wait_pulse(2, "sel 25c latency", DB + 2);
      chk("sel 25c code", sel_code, 5);
      chk("sel 25c hold", sel_hold, 4'b0100);
      sw = 4'b1100; idle(10, p);
      chk("sel multi no pulse", p, 0);
      chk("sel multi hold", sel_hold, 0);
      sw = 4'b0000; idle(10, p);
      sw = 4'b1000;
      wait_pulse(2, "sel 30c latency", DB + 2);
      chk("sel 30c code", sel_code, 6);
      sw = 4'b0000; idle(10, p);

      // Simultaneous coin and selection
      btn = 3'b001; sw = 4'b0001;
      wait_pulse(0, "simul latency", DB + 2);
      chk("simul sel_valid", sel_valid, 1);
      chk("simul amt", coin_amt, 1);
      chk("simul code", sel_code, 3);
      btn = 3'b000; sw = 4'b0000; idle(10, p);

      // Reset mid-count with the button still held
      btn = 3'b100;
      repeat (4) @(posedge clk);
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      chk("midcount reset outputs", int'({coin_valid, coin_amt, coin_err, sel_valid, sel_code, sel_err, sel_hold}), 0);
      wait_pulse(0, "post-reset latency", DB + 2);
      chk("post-reset amt", coin_amt, 5);
      btn = 3'b000; idle(10, p);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
